// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider on clock1M.
// Each channel has an active half-period, a shadow register loaded through
// a ready/valid port, and a pending flag. Pending updates land only on a
// boundary edge (or immediately when the channel is stopped), so outputs
// never glitch. A global sync realigns all channel phases.
// Build option: define CLKDIV_TICK_EN to compile in the rising-edge tick
// strobes; otherwise tick is tied to 0 and no tick registers exist.
module clk_div_multi #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 16,
    parameter logic [NUM_CH*CNT_W-1:0] RESET_HALF = {16'd50, 16'd5},
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock1M,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    logic [CNT_W-1:0]  half_q   [NUM_CH];
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  half_d   [NUM_CH];
    logic [CNT_W-1:0]  shadow_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] clk_d;
    logic              in_range;
    logic              cfg_accept;

    // Config handshake: out-of-range targets are always accepted (then dropped)
    always_comb begin
        in_range  = (32'(cfg_ch) < NUM_CH);
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(cfg_ch) == i) begin
                cfg_ready = ~pend[i];
            end
        end
        cfg_accept = cfg_valid & cfg_ready & in_range;
    end

    // Per-channel next state: sync, stopped, boundary, count; then shadow load
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            half_d[i]   = half_q[i];
            shadow_d[i] = shadow_q[i];
            cnt_d[i]    = cnt_q[i];
            pend_d[i]   = pend[i];
            clk_d[i]    = clk_out[i];

            if (sync) begin
                if (pend[i]) begin
                    half_d[i] = shadow_q[i];
                end
                pend_d[i] = 1'b0;
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
            end else if (half_q[i] == '0) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                if (pend[i]) begin
                    half_d[i] = shadow_q[i];
                    pend_d[i] = 1'b0;
                end
            end else if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
                cnt_d[i] = '0;
                if (pend[i]) begin
                    half_d[i] = shadow_q[i];
                    pend_d[i] = 1'b0;
                    clk_d[i]  = (shadow_q[i] != '0) ? ~clk_out[i] : 1'b0;
                end else begin
                    clk_d[i]  = ~clk_out[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // Accept only happens with pend clear, so this never collides with an apply
            if (cfg_accept && (32'(cfg_ch) == i)) begin
                shadow_d[i] = cfg_half;
                pend_d[i]   = 1'b1;
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clock1M or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                half_q[i]   <= RESET_HALF[i*CNT_W +: CNT_W];
                shadow_q[i] <= RESET_HALF[i*CNT_W +: CNT_W];
                cnt_q[i]    <= '0;
            end
            pend    <= '0;
            clk_out <= '0;
            cfg_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                half_q[i]   <= half_d[i];
                shadow_q[i] <= shadow_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            pend    <= pend_d;
            clk_out <= clk_d;
            cfg_err <= cfg_valid & ~in_range;
        end
    end

`ifdef CLKDIV_TICK_EN
    logic [NUM_CH-1:0] tick_q;

    // Strobe on the same edge that drives clk_out from 0 to 1
    always_ff @(posedge clock1M or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= clk_d & ~clk_out;
        end
    end

    assign tick = tick_q;
`else
    assign tick = '0;
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: reset timing, glitch-free update,
// stop/restart, sync with pending updates, back-to-back and out-of-range
// config, and reset mid-operation. Honors CLKDIV_TICK_EN for tick checks.
`timescale 1ns/1ps
module tb_clk_div_multi;

`ifdef CLKDIV_TICK_EN
    localparam bit TICK_EN = 1'b1;
`else
    localparam bit TICK_EN = 1'b0;
`endif

    logic        clock1M = 1'b0;
    logic        reset   = 1'b1;
    logic        sync    = 1'b0;

    logic        cfg_valid = 1'b0;
    logic [0:0]  cfg_ch    = 1'b0;
    logic [15:0] cfg_half  = 16'd0;
    logic        cfg_ready;
    logic        cfg_err;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [1:0]  pend;

    logic        cfg3_valid = 1'b0;
    logic [1:0]  cfg3_ch    = 2'd0;
    logic [15:0] cfg3_half  = 16'd0;
    logic        cfg3_ready;
    logic        cfg3_err;
    logic [2:0]  clk3;
    logic [2:0]  tick3;
    logic [2:0]  pend3;

    int k     = 0;
    int n_cmp = 0;
    int n_err = 0;
    int guard = 0;

    clk_div_multi dut (
        .clock1M   (clock1M),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_err   (cfg_err),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick),
        .pend      (pend)
    );

    clk_div_multi #(
        .NUM_CH     (3),
        .CNT_W      (16),
        .RESET_HALF ({16'd3, 16'd50, 16'd5})
    ) dut3 (
        .clock1M   (clock1M),
        .reset     (reset),
        .cfg_valid (cfg3_valid),
        .cfg_ready (cfg3_ready),
        .cfg_ch    (cfg3_ch),
        .cfg_half  (cfg3_half),
        .cfg_err   (cfg3_err),
        .sync      (sync),
        .clk_out   (clk3),
        .tick      (tick3),
        .pend      (pend3)
    );

    always #5 clock1M = ~clock1M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock1M);
            k++;
        end
        #1;
    endtask

    task automatic step_to(input int t);
        step(t - k);
    endtask

    // Drive one write on the main DUT, check it is accepted, then drop valid
    task automatic write(input int ch, input logic [15:0] half);
        cfg_valid = 1'b1;
        cfg_ch    = 1'(ch);
        cfg_half  = half;
        #1;
        chk("wr_ready", 32'(cfg_ready), 32'd1);
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock1M);
        #1;
        reset = 1'b0;
        k = 0;
    endtask

    // Reset-default timing: ch0 half 5, ch1 half 50, counted from release
    task automatic check_default(input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            chk("def_ch0",   32'(clk_out[0]), 32'((k / 5) % 2));
            chk("def_ch1",   32'(clk_out[1]), 32'((k / 50) % 2));
            chk("def_tick0", 32'(tick[0]),    32'(TICK_EN && (k % 10 == 5)));
            chk("def_tick1", 32'(tick[1]),    32'(TICK_EN && (k % 100 == 50)));
        end
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_clk",   32'(clk_out), 32'd0);
        chk("rst_pend",  32'(pend),    32'd0);
        chk("rst_tick",  32'(tick),    32'd0);
        chk("rst_err",   32'(cfg_err), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        do_reset();
        chk("rel_clk",   32'(clk_out), 32'd0);

        // Default divider timing over 200 edges
        check_default(200);

        // Glitch-free update of ch0 to half 2, written at cnt == 1
        step_to(201);
        write(0, 16'd2);
        chk("upd_pend202",  32'(pend[0]),   32'd1);
        chk("upd_ready202", 32'(cfg_ready), 32'd0);
        step_to(204);
        chk("upd_pend204",  32'(pend[0]),   32'd1);
        chk("upd_ready204", 32'(cfg_ready), 32'd0);
        chk("upd_clk204",   32'(clk_out[0]), 32'd0);
        step_to(205);
        chk("upd_pend205",  32'(pend[0]),   32'd0);
        chk("upd_ready205", 32'(cfg_ready), 32'd1);
        chk("upd_clk205",   32'(clk_out[0]), 32'd1);
        chk("upd_tick205",  32'(tick[0]),   32'(TICK_EN));
        for (int i = 0; i < 19; i++) begin
            step(1);
            chk("upd_ch0",   32'(clk_out[0]), 32'(((k - 205) / 2) % 2 == 0));
            chk("upd_tick0", 32'(tick[0]),    32'(TICK_EN && ((k - 205) % 4 == 0)));
        end

        // Stop ch1 while low: boundary would rise, but it is forced to 0
        step_to(310);
        write(1, 16'd0);
        chk("stop_pend311", 32'(pend[1]),    32'd1);
        step_to(349);
        chk("stop_pend349", 32'(pend[1]),    32'd1);
        chk("stop_clk349",  32'(clk_out[1]), 32'd0);
        step_to(350);
        chk("stop_pend350", 32'(pend[1]),    32'd0);
        chk("stop_clk350",  32'(clk_out[1]), 32'd0);
        chk("stop_tick350", 32'(tick[1]),    32'd0);
        for (int i = 0; i < 30; i++) begin
            step(1);
            chk("stopped_clk",  32'(clk_out[1]), 32'd0);
            chk("stopped_tick", 32'(tick[1]),    32'd0);
        end

        // Restart ch1 at half 3: applies next edge, rises 3 edges later
        write(1, 16'd3);
        chk("rs_pend381", 32'(pend[1]),    32'd1);
        step_to(382);
        chk("rs_pend382", 32'(pend[1]),    32'd0);
        chk("rs_clk382",  32'(clk_out[1]), 32'd0);
        step_to(384);
        chk("rs_clk384",  32'(clk_out[1]), 32'd0);
        step_to(385);
        chk("rs_clk385",  32'(clk_out[1]), 32'd1);
        chk("rs_tick385", 32'(tick[1]),    32'(TICK_EN));
        step_to(386);
        chk("rs_clk386",  32'(clk_out[1]), 32'd1);
        chk("rs_tick386", 32'(tick[1]),    32'd0);
        step_to(388);
        chk("rs_clk388",  32'(clk_out[1]), 32'd0);

        // sync with ch0 pending half 7 and a ch1 write in the same cycle
        step_to(390);
        write(0, 16'd7);
        chk("sy_pend391", 32'(pend[0]), 32'd1);
        sync      = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch    = 1'b1;
        cfg_half  = 16'd4;
        #1;
        chk("sy_ready1", 32'(cfg_ready), 32'd1);
        step(1);
        sync      = 1'b0;
        cfg_valid = 1'b0;
        chk("sy_clk392",   32'(clk_out), 32'd0);
        chk("sy_tick392",  32'(tick),    32'd0);
        chk("sy_pend0",    32'(pend[0]), 32'd0);
        chk("sy_pend1",    32'(pend[1]), 32'd1);
        step_to(395);
        chk("sy_ch1_395",  32'(clk_out[1]), 32'd1);
        chk("sy_pend1_395",32'(pend[1]),    32'd0);
        step_to(398);
        chk("sy_ch0_398",  32'(clk_out[0]), 32'd0);
        chk("sy_ch1_398",  32'(clk_out[1]), 32'd1);
        step_to(399);
        chk("sy_ch0_399",  32'(clk_out[0]), 32'd1);
        chk("sy_tick0_399",32'(tick[0]),    32'(TICK_EN));
        chk("sy_ch1_399",  32'(clk_out[1]), 32'd0);
        step_to(406);
        chk("sy_ch0_406",  32'(clk_out[0]), 32'd0);

        // Back-to-back writes to ch1; first lands on a boundary edge
        cfg_valid = 1'b1;
        cfg_ch    = 1'b1;
        cfg_half  = 16'd2;
        #1;
        chk("b2b_ready1", 32'(cfg_ready), 32'd1);
        step(1);
        cfg_half = 16'd6;
        #1;
        chk("b2b_ready2", 32'(cfg_ready), 32'd0);
        chk("b2b_pend",   32'(pend[1]),   32'd1);
        guard = 0;
        while (!cfg_ready && guard < 20) begin
            step(1);
            guard++;
        end
        chk("b2b_wait_k",  32'(k),          32'd411);
        chk("b2b_clk411",  32'(clk_out[1]), 32'd1);
        chk("b2b_tick411", 32'(tick[1]),    32'(TICK_EN));
        step(1);
        cfg_valid = 1'b0;
        chk("b2b_pend412", 32'(pend[1]),    32'd1);
        step_to(413);
        chk("b2b_pend413", 32'(pend[1]),    32'd0);
        chk("b2b_clk413",  32'(clk_out[1]), 32'd0);
        step_to(418);
        chk("b2b_clk418",  32'(clk_out[1]), 32'd0);
        step_to(419);
        chk("b2b_clk419",  32'(clk_out[1]), 32'd1);
        chk("b2b_err",     32'(cfg_err),    32'd0);

        // Out-of-range write on the 3-channel instance
        step_to(420);
        cfg3_valid = 1'b1;
        cfg3_ch    = 2'd3;
        cfg3_half  = 16'd1;
        #1;
        chk("oor_ready", 32'(cfg3_ready), 32'd1);
        step(1);
        cfg3_valid = 1'b0;
        chk("oor_err421",  32'(cfg3_err), 32'd1);
        chk("oor_pend421", 32'(pend3),    32'd0);
        chk("oor_main_err",32'(cfg_err),  32'd0);
        step_to(422);
        chk("oor_err422",  32'(cfg3_err), 32'd0);
        chk("oor_pend422", 32'(pend3),    32'd0);
        step_to(427);
        chk("oor_c0_427",  32'(clk3[0]),  32'd1);
        chk("oor_t0_427",  32'(tick3[0]), 32'(TICK_EN));
        chk("oor_c2_427",  32'(clk3[2]),  32'd1);

        // Reset mid-operation: ch0 high with an update pending
        chk("mr_ch0_427", 32'(clk_out[0]), 32'd1);
        write(0, 16'd3);
        chk("mr_pend428", 32'(pend[0]), 32'd1);
        step_to(429);
        chk("oor_c0_429",  32'(clk3[0]),  32'd1);
        chk("oor_c2_429",  32'(clk3[2]),  32'd0);
        step_to(430);
        chk("mr_ch0_430", 32'(clk_out[0]), 32'd1);
        chk("mr_pend430", 32'(pend[0]),    32'd1);
        reset = 1'b1;
        #1;
        chk("mr_clk",  32'(clk_out), 32'd0);
        chk("mr_pend", 32'(pend),    32'd0);
        chk("mr_tick", 32'(tick),    32'd0);
        chk("mr_err",  32'(cfg_err), 32'd0);
        chk("mr_clk3", 32'(clk3),    32'd0);
        do_reset();
        check_default(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
